// File: rtl/seg_pkg.sv
// Shared constants and elaboration helpers for the seven-segment PWM driver.
package seg_pkg;

    // Segment pattern: bit7 = dp, bits 6:0 = g..a, active-high.
    typedef logic [7:0] seg_pattern_t;

    // Hex digit to segments (g..a), active-high.
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Cycles per digit slot; a nonzero override wins over the refresh-rate math.
    function automatic int slot_len(int clk_per, int refr_rate, int num_seg, int slot_ovr);
        if (slot_ovr != 0)
            return slot_ovr;
        return 1000000000 / (clk_per * refr_rate * num_seg);
    endfunction

    // Cycles between blink phase toggles, never less than one.
    function automatic int blink_period(int clk_per, int blink_hz);
        int per;
        per = 1000000000 / (clk_per * 2 * blink_hz);
        return (per < 1) ? 1 : per;
    endfunction

    // Counter width able to hold 0..n-1, at least one bit.
    function automatic int width_of(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Hex + decimal point to active-high segment pattern.
module seven_seg_decode (
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] pattern
);
    import seg_pkg::*;

    // Table lookup with the decimal point on top.
    always_comb begin
        pattern = {dp, HEX_SEG[hex]};
    end

endmodule

// File: rtl/seven_segment_pwm.sv
// Multiplexed common-anode seven-segment driver with PWM brightness,
// blink, ghost blanking, leading-zero suppression and frame snapshot.
module seven_segment_pwm #(
    parameter int NUM_SEGMENTS  = 8,
    parameter int CLK_PER       = 10,
    parameter int REFR_RATE     = 1000,
    parameter int SLOT_OVR      = 0,
    parameter int BRIGHT_BITS   = 4,
    parameter int BLANK_CYCLES  = 16,
    parameter int BLINK_HZ      = 2,
    parameter int ANODE_ACT_LOW = 1,
    parameter int CATH_ACT_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SEGMENTS-1:0][3:0]  encoded,
    input  logic [NUM_SEGMENTS-1:0]       digit_point,
    input  logic [NUM_SEGMENTS-1:0]       digit_en,
    input  logic [NUM_SEGMENTS-1:0]       blink,
    input  logic [BRIGHT_BITS-1:0]        brightness,
    input  logic                          lz_suppress,
    output logic [0:NUM_SEGMENTS-1]       anode,
    output logic [7:0]                    cathode,
    output logic                          frame_start
);
    import seg_pkg::*;

    localparam int SLOT      = slot_len(CLK_PER, REFR_RATE, NUM_SEGMENTS, SLOT_OVR);
    localparam int BLINK_PER = blink_period(CLK_PER, BLINK_HZ);
    localparam int SLOT_W    = width_of(SLOT);
    localparam int IDX_W     = width_of(NUM_SEGMENTS);
    localparam int BLINK_W   = width_of(BLINK_PER);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_SEGMENTS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PER - 1);
    localparam logic               AN_INV     = (ANODE_ACT_LOW != 0);
    localparam logic               CA_INV     = (CATH_ACT_LOW != 0);

    if (SLOT <= BLANK_CYCLES) begin : g_slot_too_short
        $error("slot length %0d must exceed BLANK_CYCLES %0d", SLOT, BLANK_CYCLES);
    end

    logic [SLOT_W-1:0]              slot_cnt;
    logic [IDX_W-1:0]               digit_idx;
    logic [BRIGHT_BITS-1:0]         pwm_cnt;
    logic [BLINK_W-1:0]             blink_cnt;
    logic                           blink_phase;

    logic [NUM_SEGMENTS-1:0][3:0]   sh_encoded;
    logic [NUM_SEGMENTS-1:0]        sh_point, sh_en, sh_blink;
    logic [BRIGHT_BITS-1:0]         sh_bright;
    logic                           sh_lz;

    logic                           snap;
    logic [NUM_SEGMENTS-1:0][3:0]   eff_encoded;
    logic [NUM_SEGMENTS-1:0]        eff_point, eff_en, eff_blink;
    logic [BRIGHT_BITS-1:0]         eff_bright;
    logic                           eff_lz;
    logic [NUM_SEGMENTS-1:0]        suppressed;
    logic                           zero_run;
    logic                           lit;
    logic [0:NUM_SEGMENTS-1]        anode_act;
    seg_pattern_t                   pattern;

    assign snap = (slot_cnt == '0) && (digit_idx == '0);

    // During the snapshot cycle the live inputs are what the shadow is about to
    // hold, so the first cycle of a frame already shows that frame's data.
    always_comb begin
        eff_encoded = snap ? encoded     : sh_encoded;
        eff_point   = snap ? digit_point : sh_point;
        eff_en      = snap ? digit_en    : sh_en;
        eff_blink   = snap ? blink       : sh_blink;
        eff_bright  = snap ? brightness  : sh_bright;
        eff_lz      = snap ? lz_suppress : sh_lz;
    end

    // Leading zeros: scan from the top digit down while every digit is a plain enabled zero.
    always_comb begin
        zero_run   = 1'b1;
        suppressed = '0;
        for (int k = NUM_SEGMENTS - 1; k >= 1; k--) begin
            zero_run      = zero_run & (eff_encoded[k] == 4'h0) & ~eff_point[k] & eff_en[k];
            suppressed[k] = eff_lz & zero_run;
        end
    end

    assign lit = (slot_cnt >= BLANK_END)
               && (pwm_cnt < eff_bright)
               && eff_en[digit_idx]
               && !suppressed[digit_idx]
               && (!eff_blink[digit_idx] || blink_phase);

    seven_seg_decode u_decode (
        .hex     (eff_encoded[digit_idx]),
        .dp      (eff_point[digit_idx]),
        .pattern (pattern)
    );

    // One-hot select of the current digit, only while it is lit.
    always_comb begin
        anode_act            = '0;
        anode_act[digit_idx] = lit;
    end

    // Slot, digit, PWM and blink timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Capture all display inputs once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_encoded <= '0;
            sh_point   <= '0;
            sh_en      <= '0;
            sh_blink   <= '0;
            sh_bright  <= '0;
            sh_lz      <= 1'b0;
        end else if (snap) begin
            sh_encoded <= encoded;
            sh_point   <= digit_point;
            sh_en      <= digit_en;
            sh_blink   <= blink;
            sh_bright  <= brightness;
            sh_lz      <= lz_suppress;
        end
    end

    // Anode and cathode register together so a pattern never lands on a stale digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode       <= {NUM_SEGMENTS{AN_INV}};
            cathode     <= {8{CA_INV}};
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_act ^ {NUM_SEGMENTS{AN_INV}};
            cathode     <= (lit ? pattern : 8'h00) ^ {8{CA_INV}};
            frame_start <= snap;
        end
    end

endmodule
